// File: rtl/md5_job_controller.sv
// rtl/md5_job_controller.sv - MD5 search job sequencer: hash load, driver enable/reset, result capture
// Optional RUN-state watchdog: define MD5_JOB_TIMEOUT_EN.
`timescale 1ns/1ps
module md5_job_controller #(
    parameter logic [31:0] CAND_OFFSET    = 32'd0,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF,
    parameter int unsigned RST_PULSE      = 2
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic         start,
    input  logic         abort,
    output logic         enable_switch,
    output logic [127:0] target_selected,
    output logic         core_resetn,
    input  logic         status_running,
    input  logic         status_warming,
    input  logic         status_found,
    input  logic         status_done,
    input  logic [31:0]  target,
    output logic         busy,
    output logic         result_valid,
    output logic         result_found,
    output logic [31:0]  result_word,
    output logic [31:0]  cycle_count,
    output logic         timed_out,
    output logic         cmd_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        KILL  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     load_mask_q, load_mask_d;
    logic [127:0]   hash_q, hash_d;
    logic           enable_switch_q, enable_switch_d;
    logic           core_resetn_q, core_resetn_d;
    logic           busy_q, busy_d;
    logic           result_valid_q, result_valid_d;
    logic           result_found_q, result_found_d;
    logic [31:0]    result_word_q, result_word_d;
    logic [31:0]    cycle_count_q, cycle_count_d;
    logic           timed_out_q, timed_out_d;
    logic           cmd_err_q, cmd_err_d;
    logic [31:0]    pulse_cnt_q, pulse_cnt_d;
    logic           kill_req;

    always_comb begin
        state_d         = state_q;
        load_mask_d     = load_mask_q;
        hash_d          = hash_q;
        enable_switch_d = enable_switch_q;
        core_resetn_d   = core_resetn_q;
        result_valid_d  = result_valid_q;
        result_found_d  = result_found_q;
        result_word_d   = result_word_q;
        cycle_count_d   = cycle_count_q;
        timed_out_d     = timed_out_q;
        pulse_cnt_d     = pulse_cnt_q;
        cmd_err_d       = 1'b0;
        kill_req        = 1'b0;

        // The write lands before the start check so start+last-word in one cycle is accepted.
        if (wr_en) begin
            if (state_q == IDLE) begin
                load_mask_d[wr_addr]             = 1'b1;
                hash_d[{wr_addr, 5'd0} +: 32]    = wr_data;
            end else begin
                cmd_err_d = 1'b1;
            end
        end
        if (start && state_q != IDLE) begin
            cmd_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (load_mask_d == 4'hF) begin
                        state_d         = ARM;
                        enable_switch_d = 1'b1;
                        result_valid_d  = 1'b0;
                        timed_out_d     = 1'b0;
                        cycle_count_d   = 32'd0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            ARM: begin
                if (abort) begin
                    kill_req = 1'b1;
                end else if (status_running) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cycle_count_d = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q
                                                                 : cycle_count_q + 32'd1;
                if (abort) begin
                    kill_req = 1'b1;
                end else if (status_done) begin
                    result_found_d  = status_found;
                    result_word_d   = target - CAND_OFFSET;
                    enable_switch_d = 1'b0;
                    state_d         = DRAIN;
                end
`ifdef MD5_JOB_TIMEOUT_EN
                else if (cycle_count_d >= TIMEOUT_CYCLES) begin
                    timed_out_d = 1'b1;
                    kill_req    = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (abort) begin
                    kill_req = 1'b1;
                end else if (!status_done && !status_running) begin
                    result_valid_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            KILL: begin
                if (pulse_cnt_q == 32'd0) begin
                    core_resetn_d  = 1'b1;
                    result_valid_d = 1'b1;
                    result_found_d = 1'b0;
                    state_d        = IDLE;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - 32'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The driver ignores enable_switch mid-search, so cancelling means resetting it.
        if (kill_req) begin
            state_d         = KILL;
            enable_switch_d = 1'b0;
            core_resetn_d   = 1'b0;
            pulse_cnt_d     = RST_PULSE - 32'd1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            load_mask_q     <= 4'd0;
            hash_q          <= 128'd0;
            enable_switch_q <= 1'b0;
            core_resetn_q   <= 1'b1;
            busy_q          <= 1'b0;
            result_valid_q  <= 1'b0;
            result_found_q  <= 1'b0;
            result_word_q   <= 32'd0;
            cycle_count_q   <= 32'd0;
            timed_out_q     <= 1'b0;
            cmd_err_q       <= 1'b0;
            pulse_cnt_q     <= 32'd0;
        end else begin
            state_q         <= state_d;
            load_mask_q     <= load_mask_d;
            hash_q          <= hash_d;
            enable_switch_q <= enable_switch_d;
            core_resetn_q   <= core_resetn_d;
            busy_q          <= busy_d;
            result_valid_q  <= result_valid_d;
            result_found_q  <= result_found_d;
            result_word_q   <= result_word_d;
            cycle_count_q   <= cycle_count_d;
            timed_out_q     <= timed_out_d;
            cmd_err_q       <= cmd_err_d;
            pulse_cnt_q     <= pulse_cnt_d;
        end
    end

    assign enable_switch   = enable_switch_q;
    assign target_selected = hash_q;
    assign core_resetn     = core_resetn_q;
    assign busy            = busy_q;
    assign result_valid    = result_valid_q;
    assign result_found    = result_found_q;
    assign result_word     = result_word_q;
    assign cycle_count     = cycle_count_q;
    assign timed_out       = timed_out_q;
    assign cmd_err         = cmd_err_q;

    // Warming is informational only; the watchdog limit is dead when the watchdog is compiled out.
    logic unused_inputs;
`ifdef MD5_JOB_TIMEOUT_EN
    assign unused_inputs = status_warming;
`else
    assign unused_inputs = status_warming ^ (^TIMEOUT_CYCLES);
`endif

endmodule

// File: doc/md5_job_controller.md
# md5_job_controller

Host-side sequencer for the MD5 brute-force driver. Loads the 128-bit target hash from 32-bit word writes, drives the driver's `enable_switch` and active-low core reset, and tracks its status outputs through one search job. Captures the result and elapsed cycle count, then returns the driver to its start state. Sits between the bus/register glue and the MD5 driver inside the accelerator IP.

## Interface
Parameters:
- `CAND_OFFSET`, 0: value subtracted (mod 2^32) from the driver `target` when the result is captured; compensates for pipeline latency.
- `TIMEOUT_CYCLES`, 32'hFFFF_FFFF: RUN-state cycle limit. Used only with `MD5_JOB_TIMEOUT_EN`.
- `RST_PULSE`, 2: number of cycles `core_resetn` is held low on abort or timeout (≥1).

Ports:
- `CLK` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: hash word write strobe.
- `wr_addr` in 2: hash word index.
- `wr_data` in 32: hash word.
- `start` in 1: one-cycle job start request.
- `abort` in 1: one-cycle job cancel request.
- `enable_switch` out 1: to the driver.
- `target_selected` out 128: to the driver; word i maps to bits [32i+31:32i].
- `core_resetn` out 1: active-low driver reset.
- `status_running`, `status_warming`, `status_found`, `status_done` in 1 each: from the driver.
- `target` in 32: driver candidate counter.
- `busy` out 1: state is not IDLE.
- `result_valid` out 1: result registers hold a finished job.
- `result_found` out 1: the last job found a match.
- `result_word` out 32: captured `target` minus `CAND_OFFSET`.
- `cycle_count` out 32: RUN cycles of the last job; saturates at all-ones.
- `timed_out` out 1: the last job ended by timeout.
- `cmd_err` out 1: one-cycle pulse when a command is rejected.

## Operation
- States: IDLE, ARM, RUN, DRAIN, KILL.
- **Hash writes:**
  - Accepted only in IDLE. Set `load_mask[wr_addr]`.
  - Writes outside IDLE are ignored and pulse `cmd_err`.
  - `target_selected` is stable whenever `busy` = 1.
- **IDLE:**
  - `start` with `load_mask` = 4'hF → ARM. This clears `result_valid`, `timed_out` and `cycle_count`.
  - `start` with an incomplete mask → pulse `cmd_err` and stay in IDLE.
  - `start` outside IDLE → `cmd_err`.
  - `load_mask` is kept after a job, so the same hash can be re-run.
- **ARM:**
  - `enable_switch` = 1.
  - `status_running` = 1 → RUN.
- **RUN:**
  - `enable_switch` = 1; `cycle_count` increments each cycle.
  - On `status_done` = 1: capture `result_found` ← `status_found`, `result_word` ← `target` − `CAND_OFFSET`, then → DRAIN.
- **DRAIN:**
  - `enable_switch` = 0.
  - When `status_done` = 0 and `status_running` = 0: `result_valid` ← 1, → IDLE.
- **KILL:**
  - Entered on `abort` in ARM, RUN or DRAIN (the driver ignores `enable_switch` while running).
  - `core_resetn` = 0 and `enable_switch` = 0 for `RST_PULSE` cycles, then → IDLE.
  - Sets `result_valid` = 1 with `result_found` = 0.
- **Simultaneous events:**
  - `abort` and `status_done` in the same RUN cycle: abort wins, no capture.
  - `start` and `wr_en` in the same IDLE cycle: the write completes first, and the start check uses the updated mask.

## Timing
- Reset values (all outputs registered):
  - `enable_switch` = 0, `core_resetn` = 1, `target_selected` = 0.
  - `busy` = 0, `result_*` = 0, `cycle_count` = 0, `timed_out` = 0, `cmd_err` = 0.
  - State = IDLE, `load_mask` = 0.
- Latencies:
  - `start` → `enable_switch` high: next edge.
  - `status_done` → `enable_switch` low: 1 cycle.
  - `status_done` → `result_valid`: ≥3 cycles (the driver clears `status_done` one cycle after returning to start).
  - `abort` → `core_resetn` low: next edge.
- `cycle_count` counts RUN cycles, including the cycle in which `status_done` is sampled.
- `reset` asserted mid-job: immediate return to IDLE with reset values; the driver is not sequenced.

## Configuration
- `MD5_JOB_TIMEOUT_EN` defined:
  - In RUN, when `cycle_count` reaches `TIMEOUT_CYCLES`: `timed_out` ← 1, → KILL.
  - `result_valid` = 1 and `result_found` = 0 after the pulse.
- Not defined:
  - No watchdog; `timed_out` is tied to 0.
  - RUN exits only on `status_done` or `abort`.

## Test plan
- Write words 0–3, `start`; driver model raises `status_done` and `status_found` with `target` = 32'h0000_1234 and `CAND_OFFSET` = 4 → `result_found` = 1, `result_word` = 32'h0000_1230, `result_valid` = 1, `enable_switch` = 0.
- Write words 0–2 only, then `start` → `cmd_err` pulses for 1 cycle, `busy` stays 0, `enable_switch` stays 0.
- Driver exhausts the search (`status_done` = 1, `status_found` = 0) after 100 RUN cycles → `result_found` = 0, `cycle_count` = 100.
- `abort` 10 cycles into RUN → `core_resetn` low for exactly `RST_PULSE` = 2 cycles, state returns to IDLE, `result_found` = 0.
- With `MD5_JOB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50, driver never finishes → `timed_out` = 1 at RUN cycle 50, then a KILL pulse follows.
- `abort` and `status_done` in the same cycle → no capture (`result_word` = 0), KILL entered; a subsequent `wr_en` while `busy` = 1 → `cmd_err`, `target_selected` unchanged.
